// File: rtl/magnitude_comparator_seq_if.sv
// rtl/magnitude_comparator_seq_if.sv - operand/result handshake bundle for magnitude_comparator_seq
interface magnitude_comparator_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic             L;
  logic             E;
  logic             G;

  modport master (
    output in_valid, x1, x2, sgn, out_ready,
    input  in_ready, out_valid, L, E, G
  );

  modport slave (
    input  in_valid, x1, x2, sgn, out_ready,
    output in_ready, out_valid, L, E, G
  );
endinterface

// File: rtl/magnitude_comparator_seq.sv
// rtl/magnitude_comparator_seq.sv - chunk-serial magnitude comparator, MSB chunk first
// Optional early termination on the first differing chunk: MAGCMP_EARLY_EXIT_EN
module magnitude_comparator_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic                         clk,
  input logic                         rst,
  magnitude_comparator_seq_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef MAGCMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("magnitude_comparator_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [IDXW-1:0]   idx;
  logic              decided;
  logic              gt_q;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic              diff;
  logic              now_dec;
  logic              now_gt;
  logic              last;

  assign a_sh    = a_q >> (CHUNK * int'(idx));
  assign b_sh    = b_q >> (CHUNK * int'(idx));
  assign a_chunk = a_sh[CHUNK-1:0];
  assign b_chunk = b_sh[CHUNK-1:0];
  assign diff    = (a_chunk != b_chunk);

  // A result decided on a higher chunk is sticky; lower chunks only matter while undecided.
  assign now_dec = decided | diff;
  assign now_gt  = decided ? gt_q : (a_chunk > b_chunk);
  assign last    = (idx == '0) || (EARLY && diff);

  assign bus.in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      idx           <= '0;
      decided       <= 1'b0;
      gt_q          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.L         <= 1'b0;
      bus.E         <= 1'b0;
      bus.G         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            a_q     <= {bus.x1[WIDTH-1] ^ bus.sgn, bus.x1[WIDTH-2:0]};
            b_q     <= {bus.x2[WIDTH-1] ^ bus.sgn, bus.x2[WIDTH-2:0]};
            idx     <= IDXW'(NCHUNK - 1);
            decided <= 1'b0;
            gt_q    <= 1'b0;
            state   <= CMP;
          end
        end
        CMP: begin
          if (last) begin
            bus.out_valid <= 1'b1;
            bus.L         <= now_dec & ~now_gt;
            bus.E         <= ~now_dec;
            bus.G         <= now_dec & now_gt;
            state         <= DONE;
          end else begin
            idx     <= idx - 1'b1;
            decided <= now_dec;
            gt_q    <= now_gt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.L         <= 1'b0;
            bus.E         <= 1'b0;
            bus.G         <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb/tb_magnitude_comparator_seq.sv - randomized model-checked bench for magnitude_comparator_seq
module tb_magnitude_comparator_seq;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef MAGCMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [2:0] R_L = 3'b100;
  localparam logic [2:0] R_E = 3'b010;
  localparam logic [2:0] R_G = 3'b001;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  bit         pending = 1'b0;
  int         acc_cycle = 0;
  int         lat_exp = 0;
  logic [2:0] res_exp = 3'b000;

  magnitude_comparator_seq_if #(.WIDTH(WIDTH)) bus ();

  magnitude_comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [2:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit less;
    if (s) less = ($signed(a) < $signed(b));
    else   less = (a < b);
    if (a == b) return R_E;
    return less ? R_L : R_G;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a ^ b;
    if (!EARLY || d == 32'h0) return NCHUNK;
    for (int i = 31; i >= 0; i--)
      if (d[i]) return (31 - i) / CHUNK + 1;
    return NCHUNK;
  endfunction

  // Single compare process: whole visible output state versus the model, every cycle.
  always @(negedge clk) begin
    logic [4:0] act;
    logic [4:0] exp;
    act = {bus.in_ready, bus.out_valid, bus.L, bus.E, bus.G};
    if (rst)                               exp = 5'b00000;
    else if (!pending)                     exp = 5'b10000;
    else if (cycle - acc_cycle < lat_exp)  exp = 5'b00000;
    else                                   exp = {2'b01, res_exp};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cycle=%0d got {rdy,vld,L,E,G}=%b exp=%b", cycle, act, exp);
    end
  end

  task automatic scramble();
    bus.in_valid = 1'($urandom);
    bus.x1       = $urandom;
    bus.x2       = $urandom;
    bus.sgn      = 1'($urandom);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int hold, input logic [2:0] res, input int lat, input bit sync);
    if (sync) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.x1 = a; bus.x2 = b; bus.sgn = s;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    acc_cycle = cycle; lat_exp = lat; res_exp = res; pending = 1'b1;
    while (cycle < acc_cycle + lat) begin
      scramble();
      @(posedge clk); #1;
    end
    repeat (hold) begin
      scramble();
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    pending = 1'b0;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                          input logic [2:0] res, input int lat_full, input int lat_early);
    int lat;
    lat = EARLY ? lat_early : lat_full;
    checks++;
    if (model_res(a, b, s) !== res || model_lat(a, b) != lat) begin
      errors++;
      $display("FAIL model_pin a=%h b=%h s=%0d got res=%b lat=%0d exp res=%b lat=%0d",
               a, b, s, model_res(a, b, s), model_lat(a, b), res, lat);
    end
    run(a, b, s, hold, res, lat, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.x1 = '0; bus.x2 = '0; bus.sgn = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    directed(32'h005DFE00, 32'h000001AA, 1'b0, 0, R_G, 8, 3);
    directed(32'h00000003, 32'h00002040, 1'b0, 2, R_L, 8, 5);
    directed(32'h04000040, 32'h04000040, 1'b0, 1, R_E, 8, 8);
    directed(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, R_L, 8, 1);
    directed(32'hFFFFFFFF, 32'h00000001, 1'b0, 5, R_G, 8, 1);

    // Abort two cycles into a compare, then accept on the first edge after release.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.x1 = 32'h12345678; bus.x2 = 32'h12345678; bus.sgn = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc_cycle = cycle; lat_exp = NCHUNK; res_exp = R_E; pending = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; pending = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got vld=%b rdy=%b exp vld=0 rdy=0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    run(32'd5, 32'd5, 1'b0, 0, R_E, NCHUNK, 1'b0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ (32'hF << (4 * $urandom_range(0, 7)));
      endcase
      s = 1'($urandom);
      run(a, b, s, $urandom_range(0, 4), model_res(a, b, s), model_lat(a, b), 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
